piyc_uio_arbiter: RTL and testbench
===================================

# piyc_uio_arbiter

Round-robin arbiter that shares the 8-bit bidirectional `uio` pad bus of the `tt_um_RoMartino_piyc` top level between NREQ internal requesters. Grants bursts of write (pad-driving) or read (pad-sampling) beats. Drives `uio_out`/`uio_oe` from registers and returns sampled `uio_in` data to read requesters. Sits directly between the user logic and the `uio_*` top-level pins.

## Interface
- NREQ, 4, number of requesters (2..8)
- MAX_BEATS, 8, maximum beats per grant (1..255)
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ena  in  1  design enable; low blocks new grants
- req  in  NREQ  per-requester bus request, level
- wr  in  NREQ  per-requester direction: 1 = drive pads, 0 = read pads
- wdata  in  8*NREQ  write data, requester i at bits [8i+7:8i]
- gnt  out  NREQ  one-hot grant; each high cycle is one beat
- uio_in  in  8  pad input
- uio_out  out  8  pad output, registered
- uio_oe  out  8  pad output enable, registered (0xFF drive / 0x00 input)
- rdata  out  8  registered read data
- rvalid  out  1  one-cycle pulse qualifying rdata

## Operation
- States: IDLE, TURN, XFER.
- Reset: state IDLE; gnt 0, uio_out 0x00, uio_oe 0x00, rdata 0x00, rvalid 0; RR pointer = NREQ-1 (req[0] wins first); last_dir = read; beat count 0.
- IDLE: if ena and |req, winner = first set req bit scanning from pointer+1 upward with wrap. Winner index, pointer and direction are latched. Next state is TURN if a turnaround is needed (see Configuration), else XFER. uio_oe holds its previous value (bus parked).
- TURN: exactly 1 cycle. uio_oe = 0x00, gnt = 0. Then XFER.
- XFER: gnt[winner] = 1 while req[winner] is high. Each such cycle is a beat; the beat count increments.
  - Write beat: uio_out <= wdata[winner], uio_oe <= 0xFF.
  - Read beat: uio_oe <= 0x00, rdata <= uio_in, rvalid <= 1.
- XFER exit:
  - Deasserted req[winner] is sampled in the same cycle: gnt drops combinationally, no beat occurs, and the state goes to IDLE.
  - After the MAX_BEATS-th beat: IDLE.
  - last_dir <= winner direction on exit.
- wr[winner] is sampled only at arbitration. A change of wr mid-burst is ignored.
- ena low during XFER: the burst completes normally. ena only gates the IDLE decision.
- Non-winning requesters keep waiting; no request is ever dropped.
- Asynchronous rst mid-burst: immediate return to reset values. No partial-beat completion.

## Timing
- Request-to-grant: req sampled in IDLE at cycle N. gnt high at N+1 with no turnaround, N+2 with a turnaround.
- Write data: wdata presented during the gnt cycle appears on uio_out with uio_oe = 0xFF at the next edge (1-cycle latency).
- Read: uio_in sampled at the end of the gnt cycle. rdata/rvalid are valid the following cycle.
- Minimum 1 IDLE cycle between consecutive bursts. Back-to-back bursts with the same direction have a gnt gap of 1 cycle; with a turnaround, 2 cycles.
- gnt is combinational from registered state, registered winner and req[winner]. It is never high in IDLE or TURN.
- At most one gnt bit high in any cycle.

## Configuration
- PIYC_ARB_TURNAROUND_EN defined: TURN is inserted whenever the new winner's direction differs from last_dir. It is also inserted on the first write after reset. No pad is ever driven in the cycle following a read beat.
- Not defined: the TURN state is never entered. IDLE always goes straight to XFER, and uio_oe switches directly between 0x00 and 0xFF.

## Test plan
- After reset, req=4'b0001, wr[0]=1, wdata[0]=0xA5, held for 10 cycles:
  - gnt[0] high for exactly 8 cycles, then low.
  - uio_out=0xA5 and uio_oe=0xFF one cycle after the first beat.
  - With the macro, the first gnt is at N+2; without it, at N+1.
- req=4'b1111, all held, all reads: bursts are granted in order 0,1,2,3,0, each 8 beats with 1 IDLE gap. Exactly 8 rvalid pulses per burst.
- Read burst from requester 2 with uio_in=0x3C, released after 3 beats: 3 rvalid pulses with rdata=0x3C, and gnt[2] drops in the same cycle req[2] falls.
- Read burst by requester 1 then write by requester 3 (macro on): one cycle with uio_oe=0x00 and gnt=0 between them. Then uio_oe=0xFF.
- ena=0 with req=4'b0010: no gnt. Set ena=1: gnt[1] at the next arbitration. Drop ena mid-burst: the burst still runs all 8 beats.
- Assert rst during beat 4 of a write burst: gnt, uio_oe, uio_out and rvalid are 0 immediately. After release, req[0] wins first.

Source files
------------

// File: rtl/piyc_uio_arbiter_if.sv
// rtl/piyc_uio_arbiter_if.sv - requester/pad bundle shared by piyc_uio_arbiter and its users
//
// Purpose: groups the requester handshake, write data, read return and the
// uio pad signals of the piyc uio arbiter into one interface.
//
// Signals:
//   ena      design enable; low blocks new grants
//   req      per-requester bus request (level)
//   wr       per-requester direction, 1 = drive pads, 0 = read pads
//   wdata    write data, requester i at bits [8i+7:8i]
//   gnt      one-hot grant, one beat per high cycle
//   uio_in   pad input
//   uio_out  pad output (registered)
//   uio_oe   pad output enable (registered, 0xFF drive / 0x00 input)
//   rdata    registered read data
//   rvalid   one-cycle pulse qualifying rdata
//
// Modports: master = user logic / pad side, slave = arbiter.

interface piyc_uio_arbiter_if #(
  parameter int NREQ = 4
);
  logic              ena;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   wr;
  logic [8*NREQ-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        uio_in;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic [7:0]        rdata;
  logic              rvalid;

  modport master (
    output ena, req, wr, wdata, uio_in,
    input  gnt, uio_out, uio_oe, rdata, rvalid
  );

  modport slave (
    input  ena, req, wr, wdata, uio_in,
    output gnt, uio_out, uio_oe, rdata, rvalid
  );
endinterface

// File: rtl/piyc_uio_arbiter.sv
// rtl/piyc_uio_arbiter.sv - round-robin burst arbiter for the shared 8-bit uio pad bus
//
// Purpose: shares the bidirectional uio pads between NREQ requesters. A winner
// is picked round-robin in IDLE and then owns the pads for up to MAX_BEATS
// beats, either driving wdata onto the pads (write) or returning sampled
// uio_in data (read).
//
// Parameters:
//   NREQ       number of requesters (2..8)
//   MAX_BEATS  maximum beats per grant (1..255)
//
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   bus   piyc_uio_arbiter_if.slave (ena, req, wr, wdata, gnt, uio_in,
//         uio_out, uio_oe, rdata, rvalid)
//
// Build option: define PIYC_ARB_TURNAROUND_EN to insert a one-cycle TURN
// state (pads released, no grant) whenever the bus direction changes between
// bursts, including the first write after reset.

module piyc_uio_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic               clk,
  input  logic               rst,
  piyc_uio_arbiter_if.slave  bus
);

  localparam int         IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] cand;
  logic             arb_found;
  logic             win_dir;
  logic             need_turn;
  logic [7:0]       beat_cnt;

  logic             start;
  logic             beat;
  logic [NREQ-1:0]  gnt_vec;

  logic [7:0]       uio_out_q;
  logic [7:0]       uio_oe_q;
  logic [7:0]       rdata_q;
  logic             rvalid_q;

  logic [7:0]       wbyte [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_wbyte
    assign wbyte[i] = bus.wdata[8*i +: 8];
  end

  // Rotating-priority scan: the requester just after the last winner has the
  // highest priority, the last winner itself the lowest.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr;
    cand      = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!arb_found && bus.req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

`ifdef PIYC_ARB_TURNAROUND_EN
  logic last_dir;
  logic burst_end;

  assign burst_end = (state == XFER) && (state_nxt == IDLE);
  assign need_turn = (bus.wr[arb_idx] != last_dir);

  // Direction of the most recent burst; reset to read so the first write
  // after reset also pays a turnaround cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dir <= 1'b0;
    end else if (burst_end) begin
      last_dir <= win_dir;
    end
  end
`else
  assign need_turn = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant. The grant follows req[winner] combinationally so a
  // requester that lets go is released in the same cycle without a beat.
  always_comb begin
    state_nxt = state;
    gnt_vec   = '0;
    start     = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ena && arb_found) begin
          start     = 1'b1;
          state_nxt = need_turn ? TURN : XFER;
        end
      end
      TURN: begin
        state_nxt = XFER;
      end
      XFER: begin
        if (bus.req[winner]) begin
          gnt_vec[winner] = 1'b1;
          beat            = 1'b1;
          if (beat_cnt == LAST_CNT) begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Burst bookkeeping and pad/read-return registers. In IDLE the pad
  // registers simply hold, leaving the bus parked in its last direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= IDX_W'(NREQ - 1);
      winner    <= '0;
      win_dir   <= 1'b0;
      beat_cnt  <= 8'd0;
      uio_out_q <= 8'h00;
      uio_oe_q  <= 8'h00;
      rdata_q   <= 8'h00;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (start) begin
        winner   <= arb_idx;
        ptr      <= arb_idx;
        win_dir  <= bus.wr[arb_idx];
        beat_cnt <= 8'd0;
      end
      if (state == TURN) begin
        uio_oe_q <= 8'h00;
      end
      if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (win_dir) begin
          uio_out_q <= wbyte[winner];
          uio_oe_q  <= 8'hFF;
        end else begin
          uio_oe_q <= 8'h00;
          rdata_q  <= bus.uio_in;
          rvalid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt     = gnt_vec;
  assign bus.uio_out = uio_out_q;
  assign bus.uio_oe  = uio_oe_q;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;

endmodule

// File: tb/tb_piyc_uio_arbiter.sv
// tb/tb_piyc_uio_arbiter.sv - self-checking bench for piyc_uio_arbiter

module tb_piyc_uio_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BEATS = 8;
  localparam int IW        = $clog2(NREQ);
`ifdef PIYC_ARB_TURNAROUND_EN
  localparam int TURN_EN = 1;
`else
  localparam int TURN_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  piyc_uio_arbiter_if #(.NREQ(NREQ)) bus ();

  piyc_uio_arbiter #(.NREQ(NREQ), .MAX_BEATS(MAX_BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: one pending/active burst with a turnaround countdown
  // and a remaining-beat count.
  bit         m_busy;
  int         m_owner;
  int         m_delay;
  int         m_left;
  bit         m_dir;
  bit         m_last_dir;
  int         m_ptr;
  logic [7:0] e_out;
  logic [7:0] e_oe;
  logic [7:0] e_rdata;
  logic       e_rvalid;

  // Observation log
  int              b_owner[$];
  int              b_len[$];
  int              b_start[$];
  int              cyc;
  int              rv_cnt;
  logic [7:0]      last_rdata;
  logic [7:0]      snap_out;
  logic [7:0]      snap_oe;
  logic [NREQ-1:0] prev_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int owner_at(input int i);
    return (i < b_owner.size()) ? b_owner[i] : -1;
  endfunction

  function automatic int len_at(input int i);
    return (i < b_len.size()) ? b_len[i] : -1;
  endfunction

  function automatic int start_at(input int i);
    return (i < b_start.size()) ? b_start[i] : -1;
  endfunction

  task automatic model_reset();
    m_busy     = 1'b0;
    m_owner    = 0;
    m_delay    = 0;
    m_left     = 0;
    m_dir      = 1'b0;
    m_last_dir = 1'b0;
    m_ptr      = NREQ - 1;
    e_out      = 8'h00;
    e_oe       = 8'h00;
    e_rdata    = 8'h00;
    e_rvalid   = 1'b0;
  endtask

  task automatic model_step();
    int c;
    e_rvalid = 1'b0;
    if (!m_busy) begin
      if (bus.ena && (bus.req != '0)) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (bus.req[IW'(c)]) begin
            m_owner = c;
            break;
          end
        end
        m_ptr   = m_owner;
        m_dir   = bus.wr[IW'(m_owner)];
        m_left  = MAX_BEATS;
        m_delay = (TURN_EN != 0 && m_dir != m_last_dir) ? 1 : 0;
        m_busy  = 1'b1;
      end
    end else if (m_delay > 0) begin
      m_delay--;
      e_oe = 8'h00;
    end else if (bus.req[IW'(m_owner)]) begin
      if (m_dir) begin
        e_out = 8'(bus.wdata >> (8 * m_owner));
        e_oe  = 8'hFF;
      end else begin
        e_oe     = 8'h00;
        e_rdata  = bus.uio_in;
        e_rvalid = 1'b1;
      end
      m_left--;
      if (m_left == 0) begin
        m_busy     = 1'b0;
        m_last_dir = m_dir;
      end
    end else begin
      m_busy     = 1'b0;
      m_last_dir = m_dir;
    end
  endtask

  // One clock: compare at the falling edge, log, advance the model, then
  // return just after the next rising edge for the caller to drive inputs.
  task automatic cycle();
    logic [NREQ-1:0] eg;
    @(negedge clk);
    if (rst) model_reset();
    eg = '0;
    if (m_busy && m_delay == 0 && bus.req[IW'(m_owner)]) eg[IW'(m_owner)] = 1'b1;
    check("gnt", 32'(bus.gnt), 32'(eg));
    check("uio_out", 32'(bus.uio_out), 32'(e_out));
    check("uio_oe", 32'(bus.uio_oe), 32'(e_oe));
    check("rdata", 32'(bus.rdata), 32'(e_rdata));
    check("rvalid", 32'(bus.rvalid), 32'(e_rvalid));
    if (bus.gnt != '0) begin
      if (prev_gnt == '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.gnt[IW'(i)]) b_owner.push_back(i);
        b_len.push_back(1);
        b_start.push_back(cyc);
      end else begin
        b_len[b_len.size()-1] += 1;
      end
    end
    prev_gnt = bus.gnt;
    if (b_start.size() > 0 && cyc == b_start[0] + 1) begin
      snap_out = bus.uio_out;
      snap_oe  = bus.uio_oe;
    end
    if (bus.rvalid) begin
      rv_cnt++;
      last_rdata = bus.rdata;
    end
    if (!rst) model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    b_owner.delete();
    b_len.delete();
    b_start.delete();
    cyc        = 0;
    rv_cnt     = 0;
    last_rdata = 8'h00;
    snap_out   = 8'h00;
    snap_oe    = 8'h00;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = '0;
    bus.ena  = 1'b1;
    cycle();
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    rst        = 1'b1;
    bus.ena    = 1'b1;
    bus.req    = '0;
    bus.wr     = '0;
    bus.wdata  = '0;
    bus.uio_in = 8'h00;
    prev_gnt   = '0;
    model_reset();
    clear_log();
    cycle();
    cycle();
    check("reset_gnt", 32'(bus.gnt), 32'h0);
    check("reset_uio_oe", 32'(bus.uio_oe), 32'h00);
    check("reset_uio_out", 32'(bus.uio_out), 32'h00);
    check("reset_rvalid", 32'(bus.rvalid), 32'h0);
    rst = 1'b0;
    clear_log();

    // Single write burst from requester 0, request held 10 cycles
    bus.req   = 4'b0001;
    bus.wr    = 4'b0001;
    bus.wdata = 32'h0000_00A5;
    for (int i = 0; i < 10; i++) cycle();
    bus.req = '0;
    for (int i = 0; i < 4; i++) cycle();
    check("t1_bursts", b_owner.size(), 1);
    check("t1_owner", owner_at(0), 0);
    check("t1_beats", len_at(0), 8);
    check("t1_latency", start_at(0), 1 + TURN_EN);
    check("t1_uio_out", 32'(snap_out), 32'hA5);
    check("t1_uio_oe", 32'(snap_oe), 32'hFF);

    // All four requesting reads: round-robin 0,1,2,3,0
    do_reset();
    bus.req    = 4'b1111;
    bus.wr     = 4'b0000;
    bus.uio_in = 8'h5A;
    for (int i = 0; i < 45; i++) cycle();
    bus.req = '0;
    for (int i = 0; i < 3; i++) cycle();
    check("t2_bursts", b_owner.size(), 5);
    check("t2_owner0", owner_at(0), 0);
    check("t2_owner1", owner_at(1), 1);
    check("t2_owner2", owner_at(2), 2);
    check("t2_owner3", owner_at(3), 3);
    check("t2_owner4", owner_at(4), 0);
    for (int i = 0; i < 5; i++) check("t2_beats", len_at(i), 8);
    check("t2_rvalid_cnt", rv_cnt, 40);

    // Requester 2 reads 0x3C and lets go after 3 beats
    do_reset();
    bus.req    = 4'b0100;
    bus.wr     = 4'b0000;
    bus.uio_in = 8'h3C;
    for (int i = 0; i < 20 && len_at(0) < 3; i++) cycle();
    check("t3_gnt_before_drop", 32'(bus.gnt), 32'b0100);
    bus.req = '0;
    #1;
    check("t3_gnt_drop", 32'(bus.gnt), 32'h0);
    for (int i = 0; i < 4; i++) cycle();
    check("t3_beats", len_at(0), 3);
    check("t3_rvalid_cnt", rv_cnt, 3);
    check("t3_rdata", 32'(last_rdata), 32'h3C);

    // Read by requester 1, then write by requester 3
    do_reset();
    bus.req    = 4'b1010;
    bus.wr     = 4'b1000;
    bus.wdata  = 32'hC300_0000;
    bus.uio_in = 8'h00;
    for (int i = 0; i < 19; i++) cycle();
    bus.req = '0;
    for (int i = 0; i < 3; i++) cycle();
    check("t4_bursts", b_owner.size(), 2);
    check("t4_owner0", owner_at(0), 1);
    check("t4_owner1", owner_at(1), 3);
    check("t4_beats1", len_at(1), 8);
    check("t4_gap", start_at(1) - (start_at(0) + len_at(0)), 1 + TURN_EN);
    check("t4_uio_oe", 32'(bus.uio_oe), 32'hFF);
    check("t4_uio_out", 32'(bus.uio_out), 32'hC3);

    // ena gating: blocked while low, burst completes after ena drops
    do_reset();
    bus.ena = 1'b0;
    bus.req = 4'b0010;
    bus.wr  = 4'b0000;
    for (int i = 0; i < 5; i++) cycle();
    check("t5_no_gnt", b_owner.size(), 0);
    bus.ena = 1'b1;
    for (int i = 0; i < 10 && len_at(0) < 2; i++) cycle();
    bus.ena = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    bus.req = '0;
    for (int i = 0; i < 2; i++) cycle();
    bus.ena = 1'b1;
    check("t5_bursts", b_owner.size(), 1);
    check("t5_owner", owner_at(0), 1);
    check("t5_start", start_at(0), 6);
    check("t5_beats", len_at(0), 8);

    // Reset in beat 4 of a write burst
    do_reset();
    bus.req   = 4'b0001;
    bus.wr    = 4'b0001;
    bus.wdata = 32'h0000_0077;
    for (int i = 0; i < 20 && len_at(0) < 3; i++) cycle();
    check("t6_gnt_beat4", 32'(bus.gnt), 32'b0001);
    check("t6_oe_beat4", 32'(bus.uio_oe), 32'hFF);
    rst = 1'b1;
    #1;
    check("t6_rst_gnt", 32'(bus.gnt), 32'h0);
    check("t6_rst_uio_oe", 32'(bus.uio_oe), 32'h00);
    check("t6_rst_uio_out", 32'(bus.uio_out), 32'h00);
    check("t6_rst_rvalid", 32'(bus.rvalid), 32'h0);
    cycle();
    rst = 1'b0;
    clear_log();
    bus.req   = 4'b1111;
    bus.wr    = 4'b1111;
    bus.wdata = 32'h4433_2211;
    for (int i = 0; i < 12; i++) cycle();
    bus.req = '0;
    for (int i = 0; i < 3; i++) cycle();
    check("t6_first_owner", owner_at(0), 0);
    check("t6_first_beats", len_at(0), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
